// File: rtl/mips_ctrl_pc.sv
// Control-path slice of the single-cycle MIPS core: PC register, main decoder, ALU-control decoder.
// Optional macro PC_HOLD_EN adds a pc_en input that stalls the PC when low.
module mips_ctrl_pc #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
`ifdef PC_HOLD_EN
  input  logic            pc_en,
`endif
  input  logic [PC_W-1:0] pc_next,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic [PC_W-1:0] pc,
  output logic            reg_dst,
  output logic            jump,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic [1:0]      alu_op,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  logic [PC_W-1:0] r_pc;
  logic            w_opcode_illegal;
  logic            w_funct_illegal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_ADDR;
`ifdef PC_HOLD_EN
    end else if (pc_en) begin
`else
    end else begin
`endif
      r_pc <= pc_next;
    end
  end

  assign pc = r_pc;

  // Unknown opcodes fall back to all-zero strobes so they behave as a NOP.
  always_comb begin
    reg_dst          = 1'b0;
    jump             = 1'b0;
    branch           = 1'b0;
    mem_read         = 1'b0;
    mem_to_reg       = 1'b0;
    alu_op           = 2'b00;
    mem_write        = 1'b0;
    alu_src          = 1'b0;
    reg_write        = 1'b0;
    w_opcode_illegal = 1'b0;
    case (opcode)
      6'b000000: begin
        reg_dst   = 1'b1;
        alu_op    = 2'b10;
        reg_write = 1'b1;
      end
      6'b100011: begin
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        reg_write  = 1'b1;
      end
      6'b101011: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      6'b000100: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      6'b001000: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      6'b000010: begin
        jump = 1'b1;
      end
      default: w_opcode_illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_ctrl        = 4'b0010;
    w_funct_illegal = 1'b0;
    case (alu_op)
      2'b01: alu_ctrl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctrl = 4'b0010;
          6'b100010: alu_ctrl = 4'b0110;
          6'b100100: alu_ctrl = 4'b0000;
          6'b100101: alu_ctrl = 4'b0001;
          6'b100111: alu_ctrl = 4'b1100;
          6'b101010: alu_ctrl = 4'b0111;
          6'b000000: alu_ctrl = 4'b0011;
          6'b000010: alu_ctrl = 4'b0100;
          default: begin
            alu_ctrl        = 4'b1111;
            w_funct_illegal = 1'b1;
          end
        endcase
      end
      default: alu_ctrl = 4'b0010;
    endcase
  end

  assign illegal = w_opcode_illegal | w_funct_illegal;

endmodule

// File: tb/tb_mips_ctrl_pc.sv
// Directed bench for mips_ctrl_pc with a queue-based scoreboard and immediate assertions.
// Covers both the default build and the PC_HOLD_EN build.
module tb_mips_ctrl_pc;

  logic        clk;
  logic        reset;
`ifdef PC_HOLD_EN
  logic        pc_en;
`endif
  logic [31:0] pc_next;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic        reg_dst, jump, branch, mem_read, mem_to_reg;
  logic [1:0]  alu_op;
  logic        mem_write, alu_src, reg_write;
  logic [3:0]  alu_ctrl;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  mips_ctrl_pc #(.PC_W(32), .RESET_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PC_HOLD_EN
    .pc_en     (pc_en),
`endif
    .pc_next   (pc_next),
    .opcode    (opcode),
    .funct     (funct),
    .pc        (pc),
    .reg_dst   (reg_dst),
    .jump      (jump),
    .branch    (branch),
    .mem_read  (mem_read),
    .mem_to_reg(mem_to_reg),
    .alu_op    (alu_op),
    .mem_write (mem_write),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic rd, input logic j, input logic b,
                                     input logic mr, input logic m2r, input logic [1:0] aop,
                                     input logic mw, input logic as, input logic rw,
                                     input logic [3:0] ac, input logic il);
    return {rd, j, b, mr, m2r, aop, mw, as, rw, ac, il};
  endfunction

  function automatic logic [31:0] dec_obs();
    return {17'd0, reg_dst, jump, branch, mem_read, mem_to_reg, alu_op,
            mem_write, alu_src, reg_write, alu_ctrl, illegal};
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t item;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%h required=<entry>", obs);
    end else begin
      item = sb.pop_front();
      assert (obs === item.exp) else begin
        bad++;
        $error("FAIL %s observed=%h required=%h", item.tag, obs, item.exp);
      end
      $display("check %s observed=%h required=%h", item.tag, obs, item.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  ops  [7];
  logic [14:0] dexp [7];
  logic [5:0]  fns  [9];
  logic [14:0] fexp [9];

  initial begin
    ops[0] = 6'b000000; dexp[0] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0010,0);
    ops[1] = 6'b100011; dexp[1] = mk(0,0,0,1,1,2'b00,0,1,1,4'b0010,0);
    ops[2] = 6'b101011; dexp[2] = mk(0,0,0,0,0,2'b00,1,1,0,4'b0010,0);
    ops[3] = 6'b000100; dexp[3] = mk(0,0,1,0,0,2'b01,0,0,0,4'b0110,0);
    ops[4] = 6'b001000; dexp[4] = mk(0,0,0,0,0,2'b00,0,1,1,4'b0010,0);
    ops[5] = 6'b000010; dexp[5] = mk(0,1,0,0,0,2'b00,0,0,0,4'b0010,0);
    ops[6] = 6'b111111; dexp[6] = mk(0,0,0,0,0,2'b00,0,0,0,4'b0010,1);

    fns[0] = 6'b100000; fexp[0] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0010,0);
    fns[1] = 6'b100010; fexp[1] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0110,0);
    fns[2] = 6'b100100; fexp[2] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0000,0);
    fns[3] = 6'b100101; fexp[3] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0001,0);
    fns[4] = 6'b100111; fexp[4] = mk(1,0,0,0,0,2'b10,0,0,1,4'b1100,0);
    fns[5] = 6'b101010; fexp[5] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0111,0);
    fns[6] = 6'b000000; fexp[6] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0011,0);
    fns[7] = 6'b000010; fexp[7] = mk(1,0,0,0,0,2'b10,0,0,1,4'b0100,0);
    fns[8] = 6'b111111; fexp[8] = mk(1,0,0,0,0,2'b10,0,0,1,4'b1111,1);

    reset   = 1'b0;
`ifdef PC_HOLD_EN
    pc_en   = 1'b1;
`endif
    pc_next = 32'h0000_0040;
    opcode  = 6'b000000;
    funct   = 6'b100000;

    // Reset held for two edges.
    tick();
    tick();
    expect_val("pc_reset", 32'h0000_0000);
    check(pc);

    reset = 1'b1;
    expect_val("pc_first_load", 32'h0000_0040);
    tick();
    check(pc);

    pc_next = 32'h0000_0044;
    expect_val("pc_update", 32'h0000_0044);
    tick();
    check(pc);

    // Mid-run reset: nothing changes until the edge.
    reset   = 1'b0;
    pc_next = 32'h0000_0048;
    #1;
    expect_val("pc_before_sync_reset", 32'h0000_0044);
    check(pc);
    expect_val("pc_mid_reset", 32'h0000_0000);
    tick();
    check(pc);

    reset   = 1'b1;
    pc_next = 32'h0000_0010;
    expect_val("pc_reload", 32'h0000_0010);
    tick();
    check(pc);

`ifdef PC_HOLD_EN
    pc_en   = 1'b0;
    pc_next = 32'h0000_0014;
    for (int i = 0; i < 3; i++) begin
      expect_val($sformatf("pc_hold_%0d", i), 32'h0000_0010);
      tick();
      check(pc);
    end
    pc_en = 1'b1;
    expect_val("pc_en_load", 32'h0000_0014);
    tick();
    check(pc);
    pc_en = 1'b0;
    reset = 1'b0;
    expect_val("pc_reset_over_hold", 32'h0000_0000);
    tick();
    check(pc);
    reset = 1'b1;
`else
    pc_next = 32'h0000_0014;
    expect_val("pc_free_load", 32'h0000_0014);
    tick();
    check(pc);
`endif

    funct = 6'b100000;
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i];
      expect_val($sformatf("dec_op_%b", ops[i]), {17'd0, dexp[i]});
      #1;
      check(dec_obs());
    end

    opcode = 6'b000000;
    for (int i = 0; i < 9; i++) begin
      funct = fns[i];
      expect_val($sformatf("rtype_fn_%b", fns[i]), {17'd0, fexp[i]});
      #1;
      check(dec_obs());
    end

    // funct must be ignored outside R-type.
    opcode = 6'b100011;
    funct  = 6'b100010;
    expect_val("lw_fn_ignored", {17'd0, mk(0,0,0,1,1,2'b00,0,1,1,4'b0010,0)});
    #1;
    check(dec_obs());

    opcode = 6'b000100;
    funct  = 6'b100100;
    expect_val("beq_fn_ignored", {17'd0, mk(0,0,1,0,0,2'b01,0,0,0,4'b0110,0)});
    #1;
    check(dec_obs());

    opcode = 6'b001000;
    funct  = 6'b111111;
    expect_val("addi_bad_fn_ignored", {17'd0, mk(0,0,0,0,0,2'b00,0,1,1,4'b0010,0)});
    #1;
    check(dec_obs());

    // Decoder outputs must not depend on reset.
    reset  = 1'b0;
    opcode = 6'b101011;
    expect_val("sw_during_reset", {17'd0, mk(0,0,0,0,0,2'b00,1,1,0,4'b0010,0)});
    #1;
    check(dec_obs());
    reset = 1'b1;

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_pc.md
Name: mips_ctrl_pc

Overview:
- Control-path slice of the single-cycle MIPS core.
- Combines three functions:
  - the program-counter register;
  - the main opcode decoder that produces datapath control strobes and the 2-bit ALUOp;
  - the ALU-control decoder that turns ALUOp plus the funct field into a 4-bit ALU operation code.
- Sits between instruction memory (opcode/funct in) and the datapath muxes, register file, data memory and ALU.

Parameters:
- PC_W, 32, program-counter width in bits.
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; PC updates on its rising edge.
- reset  in  1  synchronous, active-low reset; 0 sampled at a rising clk edge resets the PC.
- pc_next  in  PC_W  next PC value, already selected by the datapath branch/jump muxes.
- opcode  in  6  instruction bits [31:26].
- funct  in  6  instruction bits [5:0].
- pc  out  PC_W  current PC (registered).
- reg_dst  out  1  1 = write register is rd, 0 = rt.
- jump  out  1  selects the jump target.
- branch  out  1  ANDed with ALU zero by the datapath.
- mem_read  out  1  data-memory read enable.
- mem_to_reg  out  1  1 = writeback from memory.
- alu_op  out  2  00 add, 01 sub, 10 use funct, 11 unused.
- mem_write  out  1  data-memory write enable.
- alu_src  out  1  1 = sign-extended immediate operand.
- reg_write  out  1  register-file write enable.
- alu_ctrl  out  4  ALU operation code.
- illegal  out  1  unsupported opcode, or unsupported funct when alu_op = 10.

Behaviour:
- PC register:
  - At each rising clk: if reset = 0, pc <= RESET_ADDR; else pc <= pc_next.
  - No asynchronous path.
  - Reset asserted mid-run takes effect at the next edge, regardless of pc_next.
  - After reset deasserts, the first edge loads pc_next.
  - pc is X-free from the first reset edge onward.
- Main decoder is purely combinational from opcode, with zero latency. Listed as reg_dst, jump, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write:
  - 000000 R-type: 1,0,0,0,0,10,0,0,1
  - 100011 lw: 0,0,0,1,1,00,0,1,1
  - 101011 sw: 0,0,0,0,0,00,1,1,0
  - 000100 beq: 0,0,1,0,0,01,0,0,0
  - 001000 addi: 0,0,0,0,0,00,0,1,1
  - 000010 j: 0,1,0,0,0,00,0,0,0
  - Any other opcode: all strobes 0, alu_op = 00, illegal = 1. No state side effects, so it is safe as a NOP.
- ALU-control decoder is combinational from alu_op and funct:
  - alu_op 00 -> 0010 (add).
  - alu_op 01 -> 0110 (sub).
  - alu_op 11 -> 0010, and illegal stays 0.
  - alu_op 10, decoded by funct:
    - 100000 add -> 0010
    - 100010 sub -> 0110
    - 100100 and -> 0000
    - 100101 or -> 0001
    - 100111 nor -> 1100
    - 101010 slt -> 0111
    - 000000 sll -> 0011
    - 000010 srl -> 0100
    - any other funct -> 1111 and illegal = 1.
- funct is ignored whenever alu_op != 10.
- illegal = opcode_illegal OR funct_illegal.
- All decoder outputs are independent of clk and reset. Reset affects only pc.

Optional Feature:
- Macro PC_HOLD_EN.
- When defined:
  - Adds input port pc_en (1 bit), placed after reset.
  - On a rising edge with reset = 1 and pc_en = 0, pc holds its value.
  - With pc_en = 1, pc loads pc_next.
  - reset still has priority over pc_en.
- When undefined:
  - No pc_en port exists.
  - pc loads pc_next on every non-reset edge.
  - Decoder behaviour is identical in both builds.

Test Plan:
- Reset and update:
  - Hold reset = 0 for 2 edges with pc_next = 32'h0000_0040 -> pc = 0.
  - Release reset; next edge -> pc = 32'h40.
  - Set pc_next = 32'h44; next edge -> pc = 32'h44.
- Reset mid-run: at pc = 32'h44, drive reset = 0 for 1 edge -> pc = 0 exactly at that edge. No change appears before the edge (synchronous).
- Opcode sweep:
  - Apply 000000, 100011, 101011, 000100, 001000, 000010 -> each strobe vector matches the decoder list above, with illegal = 0.
  - Apply 111111 -> all strobes 0, alu_op = 00, illegal = 1.
- R-type funct sweep:
  - With opcode = 000000, apply funct values 100000, 100010, 100100, 100101, 100111, 101010, 000000, 000010 -> alu_ctrl = 0010, 0110, 0000, 0001, 1100, 0111, 0011, 0100 respectively.
  - With funct = 111111 -> alu_ctrl = 1111, illegal = 1.
- funct ignored outside R-type:
  - opcode = 100011 with funct = 100010 -> alu_ctrl = 0010.
  - opcode = 000100 with funct = 100100 -> alu_ctrl = 0110.
  - Both cases -> illegal = 0.
- PC_HOLD_EN build:
  - pc = 32'h10, pc_en = 0, pc_next = 32'h14 for 3 edges -> pc stays 32'h10.
  - Set pc_en = 1 -> pc = 32'h14 at the next edge.
  - reset = 0 with pc_en = 0 -> pc = 0.
